memory_writeback_stage: RTL

// Consumer end of the EX/MEM pipeline interface. It takes the *_xm control and data bundle and

---
 rtl/memory_writeback_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/memory_writeback_stage.sv
// EX/MEM consumer: runs loads/stores against a req/ack data memory, stalls upstream
// while an access is outstanding, and captures one MEM/WB record per instruction.
module memory_writeback_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt_xm,
  input  logic              mem_read_xm,
  input  logic              mem_write_xm,
  input  logic              mem_to_reg_xm,
  input  logic              reg_write_xm,
  input  logic              pcs_xm,
  input  logic [REG_W-1:0]  write_reg_xm,
  input  logic [3:0]        opcode_xm,
  input  logic [DATA_W-1:0] next_pc_xm,
  input  logic [DATA_W-1:0] reg2_xm,
  input  logic [DATA_W-1:0] alu_out_xm,
  output logic              stall_xm,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              hlt_mw,
  output logic              reg_write_mw,
  output logic              mem_to_reg_mw,
  output logic              pcs_mw,
  output logic [REG_W-1:0]  write_reg_mw,
  output logic [3:0]        opcode_mw,
  output logic [DATA_W-1:0] mem_data_mw,
  output logic [DATA_W-1:0] wb_data_mw
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic              hlt;
    logic              reg_write;
    logic              mem_to_reg;
    logic              pcs;
    logic [REG_W-1:0]  write_reg;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] wb_data;
  } mw_t;

  state_t            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  mw_t               mw_q, mw_d;
  logic              memop;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mw_d     = '0;
    stall_xm = 1'b0;
    memop    = mem_read_xm | mem_write_xm;

    unique case (state_q)
      IDLE: begin
        if (memop) begin
          stall_xm = 1'b1;
          state_d  = ACCESS;
          req_d    = 1'b1;
          we_d     = mem_write_xm;
          addr_d   = alu_out_xm;
          wdata_d  = reg2_xm;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          stall_xm = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled cycle leaves mw_d as an all-zero bubble.
    if (!stall_xm) begin
      mw_d.hlt        = hlt_xm;
      mw_d.reg_write  = reg_write_xm;
      mw_d.mem_to_reg = mem_to_reg_xm;
      mw_d.pcs        = pcs_xm;
      mw_d.write_reg  = write_reg_xm;
      mw_d.opcode     = opcode_xm;
      // Read-and-write was issued as a write, so the latched we decides.
      mw_d.mem_data   = (state_q == ACCESS && !we_q) ? dmem_rdata : '0;
      mw_d.wb_data    = pcs_xm ? next_pc_xm : (mem_to_reg_xm ? mw_d.mem_data : alu_out_xm);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mw_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mw_q    <= mw_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign hlt_mw        = mw_q.hlt;
  assign reg_write_mw  = mw_q.reg_write;
  assign mem_to_reg_mw = mw_q.mem_to_reg;
  assign pcs_mw        = mw_q.pcs;
  assign write_reg_mw  = mw_q.write_reg;
  assign opcode_mw     = mw_q.opcode;
  assign mem_data_mw   = mw_q.mem_data;
  assign wb_data_mw    = mw_q.wb_data;

endmodule
